// File: rtl/ibex_ipm_issue.sv
// Issue stage in front of the IPM multiplier: latches one request, pulses the start,
// watches for completion with a watchdog and holds the result until ID retires it.
//
// state  | meaning
// IDLE   | ready for a new request from ID
// ISSUE  | start pulse to the multiplier, watchdog cleared
// WAIT   | waiting for ipm_valid_i, watchdog running
// DONE   | result held on result_o until consumed or flushed
module ibex_ipm_issue #(
  parameter int unsigned OpW           = 2,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned CntW          = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OpW-1:0]  req_op_i,
  input  logic [31:0]     req_a_i,
  input  logic [31:0]     req_b_i,
  input  logic            flush_i,
  output logic [OpW-1:0]  ipm_operator_o,
  output logic [31:0]     ipm_operand_a_o,
  output logic [31:0]     ipm_operand_b_o,
  output logic            ipm_en_o,
  output logic            ipm_sel_o,
  input  logic [31:0]     ipm_result_i,
  input  logic            ipm_valid_i,
  input  logic            ipm_ready_id_i,
  output logic [31:0]     result_o,
  output logic            result_valid_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [OpW-1:0]  r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_result;
  logic            r_timeout;
  logic            w_capture;
  logic            w_res_load;
  logic            w_timeout_hit;

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_res_load    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (ipm_valid_i) begin
          w_res_load  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (ipm_valid_i) begin
          w_res_load  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CntLast) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || ipm_ready_id_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_op <= req_op_i;
        r_a  <= req_a_i;
        r_b  <= req_b_i;
      end
      // Saturating watchdog so a stuck multiplier can never wrap it back to zero.
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && r_cnt != CntMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_res_load) begin
        r_result <= ipm_result_i;
      end else if (w_timeout_hit) begin
        r_result  <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  // A flush in ISSUE suppresses the start pulse so the multiplier never begins.
  assign ipm_en_o        = (r_state == S_ISSUE) && !flush_i;
  assign ipm_sel_o       = (r_state != S_IDLE);
  assign req_ready_o     = (r_state == S_IDLE);
  assign result_valid_o  = (r_state == S_DONE);
  assign result_o        = r_result;
  assign timeout_o       = r_timeout;
  assign ipm_operator_o  = r_op;
  assign ipm_operand_a_o = r_a;
  assign ipm_operand_b_o = r_b;

endmodule

// File: tb/tb_ibex_ipm_issue.sv
// Directed bench for ibex_ipm_issue: each task drives one scenario and checks
// hand-computed values one step after the rising edge.
module tb_ibex_ipm_issue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic        flush_i;
  logic [1:0]  ipm_operator_o;
  logic [31:0] ipm_operand_a_o;
  logic [31:0] ipm_operand_b_o;
  logic        ipm_en_o;
  logic        ipm_sel_o;
  logic [31:0] ipm_result_i;
  logic        ipm_valid_i;
  logic        ipm_ready_id_i;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        timeout_o;

  int vecs = 0;
  int errs = 0;

  ibex_ipm_issue #(.OpW(2), .TimeoutCycles(8), .CntW(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .flush_i(flush_i),
    .ipm_operator_o(ipm_operator_o), .ipm_operand_a_o(ipm_operand_a_o),
    .ipm_operand_b_o(ipm_operand_b_o), .ipm_en_o(ipm_en_o), .ipm_sel_o(ipm_sel_o),
    .ipm_result_i(ipm_result_i), .ipm_valid_i(ipm_valid_i),
    .ipm_ready_id_i(ipm_ready_id_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    flush_i = 1'b0; ipm_result_i = '0; ipm_valid_i = 1'b0; ipm_ready_id_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    settle();
    vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
    vecs++; if ({ipm_en_o, ipm_sel_o, result_valid_o, timeout_o} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags got %b want 0000", {ipm_en_o, ipm_sel_o, result_valid_o, timeout_o}); end
    vecs++; if ({ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o, result_o} !== 98'd0) begin
      errs++; $display("FAIL reset_regs got %h want 0", {ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o, result_o}); end
  endtask

  task automatic test_basic();
    req_valid_i = 1'b1; req_op_i = 2'd1; req_a_i = 32'h3; req_b_i = 32'h5;
    tick();                                  // cycle 1: ISSUE
    req_valid_i = 1'b0;
    settle();
    vecs++; if ({ipm_en_o, ipm_sel_o, req_ready_o} !== 3'b110) begin
      errs++; $display("FAIL basic_issue en/sel/ready got %b want 110", {ipm_en_o, ipm_sel_o, req_ready_o}); end
    vecs++; if ({ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o} !== {2'd1, 32'h3, 32'h5}) begin
      errs++; $display("FAIL basic_operands got %h want %h", {ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o}, {2'd1, 32'h3, 32'h5}); end
    tick();                                  // cycle 2: WAIT
    vecs++; if ({ipm_en_o, ipm_sel_o, result_valid_o} !== 3'b010) begin
      errs++; $display("FAIL basic_wait2 en/sel/rv got %b want 010", {ipm_en_o, ipm_sel_o, result_valid_o}); end
    tick();                                  // cycle 3: multiplier completes
    ipm_valid_i = 1'b1; ipm_result_i = 32'h0000_000F;
    settle();
    vecs++; if ({ipm_en_o, result_valid_o} !== 2'b00) begin
      errs++; $display("FAIL basic_wait3 en/rv got %b want 00", {ipm_en_o, result_valid_o}); end
    tick();                                  // cycle 4: DONE
    ipm_valid_i = 1'b0; ipm_result_i = 32'hFFFF_FFFF;
    settle();
    vecs++; if (result_valid_o !== 1'b1) begin errs++; $display("FAIL basic_rv got %b want 1", result_valid_o); end
    vecs++; if (result_o !== 32'h0000_000F) begin errs++; $display("FAIL basic_result got %h want 0000000f", result_o); end
  endtask

  task automatic test_backpressure();
    req_valid_i = 1'b1; req_op_i = 2'd2; req_a_i = 32'h11; req_b_i = 32'h22;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if ({result_valid_o, req_ready_o, ipm_sel_o} !== 3'b101) begin
        errs++; $display("FAIL bp_flags[%0d] rv/ready/sel got %b want 101", i, {result_valid_o, req_ready_o, ipm_sel_o}); end
      vecs++; if ({result_o, ipm_operand_a_o, ipm_operand_b_o, ipm_operator_o} !== {32'hF, 32'h3, 32'h5, 2'd1}) begin
        errs++; $display("FAIL bp_hold[%0d] got %h want %h", i, {result_o, ipm_operand_a_o, ipm_operand_b_o, ipm_operator_o}, {32'hF, 32'h3, 32'h5, 2'd1}); end
    end
    req_valid_i = 1'b0; ipm_ready_id_i = 1'b1;
    tick();
    ipm_ready_id_i = 1'b0;
    settle();
    vecs++; if ({result_valid_o, req_ready_o, ipm_sel_o} !== 3'b010) begin
      errs++; $display("FAIL bp_release rv/ready/sel got %b want 010", {result_valid_o, req_ready_o, ipm_sel_o}); end
  endtask

  task automatic test_zero_latency();
    req_valid_i = 1'b1; req_op_i = 2'd3; req_a_i = 32'h7; req_b_i = 32'h9;
    tick();                                  // ISSUE with immediate completion
    req_valid_i = 1'b0; ipm_valid_i = 1'b1; ipm_result_i = 32'hDEAD_BEEF;
    settle();
    vecs++; if (ipm_en_o !== 1'b1) begin errs++; $display("FAIL zl_en got %b want 1", ipm_en_o); end
    tick();
    ipm_valid_i = 1'b0; ipm_result_i = '0;
    settle();
    vecs++; if ({result_valid_o, result_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL zl_done got %b/%h want 1/deadbeef", result_valid_o, result_o); end
    ipm_ready_id_i = 1'b1;
    tick();
    ipm_ready_id_i = 1'b0;
  endtask

  task automatic test_timeout();
    req_valid_i = 1'b1; req_op_i = 2'd1; req_a_i = 32'h2; req_b_i = 32'h3;
    tick();                                  // ISSUE
    req_valid_i = 1'b0;
    tick();                                  // WAIT cycle 1
    for (int i = 2; i <= 8; i++) begin
      tick();                                // WAIT cycle i
      vecs++; if ({result_valid_o, timeout_o} !== 2'b00) begin
        errs++; $display("FAIL to_wait[%0d] rv/timeout got %b want 00", i, {result_valid_o, timeout_o}); end
    end
    tick();                                  // DONE after 8 WAIT cycles
    vecs++; if ({timeout_o, result_valid_o, result_o} !== {1'b1, 1'b1, 32'h0}) begin
      errs++; $display("FAIL to_done got %b/%b/%h want 1/1/00000000", timeout_o, result_valid_o, result_o); end
    ipm_ready_id_i = 1'b1;
    tick();
    ipm_ready_id_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = 2'd2; req_a_i = 32'h6; req_b_i = 32'h7;
    tick();
    req_valid_i = 1'b0; ipm_valid_i = 1'b1; ipm_result_i = 32'h0000_002A;
    tick();
    ipm_valid_i = 1'b0;
    settle();
    vecs++; if ({timeout_o, result_valid_o, result_o} !== {1'b1, 1'b1, 32'h2A}) begin
      errs++; $display("FAIL to_next got %b/%b/%h want 1/1/0000002a", timeout_o, result_valid_o, result_o); end
    ipm_ready_id_i = 1'b1;
    tick();
    ipm_ready_id_i = 1'b0;
  endtask

  task automatic test_flush();
    req_valid_i = 1'b1; req_op_i = 2'd1; req_a_i = 32'h8; req_b_i = 32'h8;
    tick();
    req_valid_i = 1'b0;
    tick();                                  // WAIT
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; ipm_valid_i = 1'b1; ipm_result_i = 32'h55;
    settle();
    vecs++; if ({req_ready_o, result_valid_o, ipm_sel_o} !== 3'b100) begin
      errs++; $display("FAIL flush_wait ready/rv/sel got %b want 100", {req_ready_o, result_valid_o, ipm_sel_o}); end
    tick();
    ipm_valid_i = 1'b0;
    vecs++; if ({req_ready_o, result_valid_o, result_o} !== {1'b1, 1'b0, 32'h2A}) begin
      errs++; $display("FAIL flush_late got %b/%b/%h want 1/0/0000002a", req_ready_o, result_valid_o, result_o); end
    req_valid_i = 1'b1; req_a_i = 32'h44; req_b_i = 32'h45;
    tick();                                  // ISSUE
    req_valid_i = 1'b0; flush_i = 1'b1;
    settle();
    vecs++; if (ipm_en_o !== 1'b0) begin errs++; $display("FAIL flush_issue_en got %b want 0", ipm_en_o); end
    tick();
    vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL flush_issue_ready got %b want 1", req_ready_o); end
    req_valid_i = 1'b1; req_a_i = 32'h99;    // flush still high: no capture
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    settle();
    vecs++; if ({req_ready_o, ipm_en_o, ipm_operand_a_o} !== {1'b1, 1'b0, 32'h44}) begin
      errs++; $display("FAIL flush_idle got %b/%b/%h want 1/0/00000044", req_ready_o, ipm_en_o, ipm_operand_a_o); end
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_op_i = 2'd3; req_a_i = 32'h12; req_b_i = 32'h34;
    tick();
    req_valid_i = 1'b0;
    tick();                                  // WAIT, timeout_o still set from earlier
    rst_i = 1'b1; ipm_valid_i = 1'b1; ipm_result_i = 32'h77;
    tick();
    rst_i = 1'b0; ipm_valid_i = 1'b0;
    settle();
    vecs++; if ({req_ready_o, ipm_en_o, ipm_sel_o, result_valid_o, timeout_o} !== 5'b10000) begin
      errs++; $display("FAIL rst_mid_flags got %b want 10000", {req_ready_o, ipm_en_o, ipm_sel_o, result_valid_o, timeout_o}); end
    vecs++; if ({ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o, result_o} !== 98'd0) begin
      errs++; $display("FAIL rst_mid_regs got %h want 0", {ipm_operator_o, ipm_operand_a_o, ipm_operand_b_o, result_o}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_latency();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
